// File: rtl/cpu_interlock_pkg.sv
// Shared definitions for the execute-boundary interlock:
// op encodings, multi-cycle latencies, FSM state type and op classifiers.
package cpu_interlock_pkg;

    localparam int OP_W  = 6;
    localparam int REG_W = 4;
    localparam int NREG  = 16;
    localparam int CNT_W = 5;

    localparam logic [OP_W-1:0] OP_NOP    = 6'h00;
    localparam logic [OP_W-1:0] OP_ADD_L  = 6'h01;
    localparam logic [OP_W-1:0] OP_SUB_L  = 6'h02;
    localparam logic [OP_W-1:0] OP_AND_L  = 6'h03;
    localparam logic [OP_W-1:0] OP_OR_L   = 6'h04;

    localparam logic [OP_W-1:0] OP_LDI_L  = 6'h10;
    localparam logic [OP_W-1:0] OP_LDI_B  = 6'h11;
    localparam logic [OP_W-1:0] OP_LDI_S  = 6'h12;
    localparam logic [OP_W-1:0] OP_LDA_L  = 6'h13;
    localparam logic [OP_W-1:0] OP_LDA_B  = 6'h14;
    localparam logic [OP_W-1:0] OP_LDA_S  = 6'h15;
    localparam logic [OP_W-1:0] OP_LD_L   = 6'h16;
    localparam logic [OP_W-1:0] OP_LD_B   = 6'h17;
    localparam logic [OP_W-1:0] OP_LD_S   = 6'h18;
    localparam logic [OP_W-1:0] OP_LDO_L  = 6'h19;
    localparam logic [OP_W-1:0] OP_LDO_B  = 6'h1A;
    localparam logic [OP_W-1:0] OP_LDO_S  = 6'h1B;

    localparam logic [OP_W-1:0] OP_MUL_L  = 6'h20;
    localparam logic [OP_W-1:0] OP_DIV_L  = 6'h21;
    localparam logic [OP_W-1:0] OP_UDIV_L = 6'h22;
    localparam logic [OP_W-1:0] OP_MOD_L  = 6'h23;
    localparam logic [OP_W-1:0] OP_UMOD_L = 6'h24;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 32;

    typedef enum logic {
        ST_IDLE,
        ST_MULTI
    } state_t;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return op inside {OP_LDI_L, OP_LDI_B, OP_LDI_S,
                          OP_LDA_L, OP_LDA_B, OP_LDA_S,
                          OP_LD_L,  OP_LD_B,  OP_LD_S,
                          OP_LDO_L, OP_LDO_B, OP_LDO_S};
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return op inside {OP_DIV_L, OP_UDIV_L, OP_MOD_L, OP_UMOD_L};
    endfunction

    function automatic logic is_multi(input logic [OP_W-1:0] op);
        return (op == OP_MUL_L) || is_div(op);
    endfunction

    // Counter preload: the issue cycle and the final (count==0) cycle
    // together account for the remaining two cycles of latency.
    function automatic logic [CNT_W-1:0] mc_init(input logic [OP_W-1:0] op);
        return is_div(op) ? CNT_W'(DIV_LAT - 2) : CNT_W'(MUL_LAT - 2);
    endfunction

endpackage

// File: rtl/cpu_interlock_if.sv
// Execute-boundary bundle between decode/memory and the interlock.
// master: decode/memory side; slave: the interlock itself.
interface cpu_interlock_if;
    import cpu_interlock_pkg::*;

    logic              valid_i;
    logic [OP_W-1:0]   op_i;
    logic [REG_W-1:0]  riA_i;
    logic [REG_W-1:0]  riB_i;
    logic              flush_i;
    logic              ld_done_i;
    logic [REG_W-1:0]  ld_index_i;
    logic              stall_o;
    logic              issue_o;
    logic              mc_done_o;
    logic [NREG-1:0]   pending_o;

    modport master (
        output valid_i, op_i, riA_i, riB_i, flush_i,
        output ld_done_i, ld_index_i,
        input  stall_o, issue_o, mc_done_o, pending_o
    );

    modport slave (
        input  valid_i, op_i, riA_i, riB_i, flush_i,
        input  ld_done_i, ld_index_i,
        output stall_o, issue_o, mc_done_o, pending_o
    );

endinterface

// File: rtl/cpu_scoreboard.sv
// 16-entry outstanding-load scoreboard with one set port, one clear port
// and two read ports that see a same-cycle clear (bypass).
module cpu_scoreboard
    import cpu_interlock_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_idx,
    input  logic [REG_W-1:0] rd_a,
    input  logic [REG_W-1:0] rd_b,
    output logic             hit_a,
    output logic             hit_b,
    output logic [NREG-1:0]  pending
);

    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] pend_eff;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_idx] = 1'b1;
        if (clr_en) clr_mask[clr_idx] = 1'b1;
    end

    // Returning load data is visible to the hazard check this cycle.
    assign pend_eff = pending & ~clr_mask;
    assign hit_a    = pend_eff[rd_a];
    assign hit_b    = pend_eff[rd_b];

    // A new load to the register being retired keeps the bit set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pending <= '0;
        else       pending <= pend_eff | set_mask;
    end

endmodule

// File: rtl/cpu_interlock.sv
// Execute-boundary interlock: load-use scoreboard stalls plus a
// multi-cycle FSM that freezes fetch/decode while MUL/DIV ops run.
// Ports: clk_i, rst_i (async, active high), bus (slave modport).
module cpu_interlock
    import cpu_interlock_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    cpu_interlock_if.slave  bus
);

    state_t            state, state_n;
    logic [CNT_W-1:0]  count, count_n;
    logic              hit_a, hit_b;
    logic              hazard;
    logic              stall;
    logic              issue;
    logic              mc_done;
    logic              ld_issue;
    logic              mc_issue;
    logic [NREG-1:0]   pending;

    cpu_scoreboard u_sb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .set_en  (ld_issue),
        .set_idx (bus.riA_i),
        .clr_en  (bus.ld_done_i),
        .clr_idx (bus.ld_index_i),
        .rd_a    (bus.riA_i),
        .rd_b    (bus.riB_i),
        .hit_a   (hit_a),
        .hit_b   (hit_b),
        .pending (pending)
    );

    assign hazard = bus.valid_i & (hit_a | hit_b);

    // Reset gating keeps decode quiet even if valid_i floats high.
    assign stall = ~rst_i & (hazard | (state == ST_MULTI));
    assign issue = ~rst_i & bus.valid_i & ~stall & ~bus.flush_i;

    assign ld_issue = issue & is_load(bus.op_i);
    assign mc_issue = issue & is_multi(bus.op_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end

    // flush_i is not an input here: a running op predates the branch.
    always_comb begin
        state_n = state;
        count_n = count;
        mc_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (mc_issue) begin
                    state_n = ST_MULTI;
                    count_n = mc_init(bus.op_i);
                end
            end
            ST_MULTI: begin
                if (count == '0) begin
                    state_n = ST_IDLE;
                    mc_done = 1'b1;
                end else begin
                    count_n = count - 1'b1;
                end
            end
        endcase
    end

    assign bus.stall_o   = stall;
    assign bus.issue_o   = issue;
    assign bus.mc_done_o = mc_done;
    assign bus.pending_o = pending;

endmodule

// File: tb/tb_cpu_interlock.sv
// Directed-vector bench for cpu_interlock: load-use stalls, MUL/DIV
// latency, flush handling, scoreboard set/clear races and reset abort.
module tb_cpu_interlock;
    import cpu_interlock_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_st;
    int   n_mc;
    int   mc_at;

    cpu_interlock_if bus ();

    cpu_interlock dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op,
                         input logic [3:0] a, input logic [3:0] b);
        bus.valid_i = v;
        bus.op_i    = op;
        bus.riA_i   = a;
        bus.riB_i   = b;
    endtask

    task automatic ldret(input logic d, input logic [3:0] idx);
        bus.ld_done_i  = d;
        bus.ld_index_i = idx;
    endtask

    initial begin
        drive(1'b1, OP_ADD_L, 4'd1, 4'd2);
        bus.flush_i = 1'b0;
        ldret(1'b0, 4'd0);

        // reset state with valid_i held high
        tick;
        tick;
        #1;
        chk("rst_stall", 32'(bus.stall_o), 32'd0);
        chk("rst_issue", 32'(bus.issue_o), 32'd0);
        chk("rst_pend", 32'(bus.pending_o), 32'h0);
        chk("rst_mcd", 32'(bus.mc_done_o), 32'd0);
        rst = 1'b0;

        // load-use: LDA_L r3 then ADD_L using r3
        tick;
        drive(1'b1, OP_LDA_L, 4'd3, 4'd0);
        #1;
        chk("lda_issue", 32'(bus.issue_o), 32'd1);
        chk("lda_stall", 32'(bus.stall_o), 32'd0);
        tick;
        drive(1'b1, OP_ADD_L, 4'd1, 4'd3);
        #1;
        chk("lu_pend", 32'(bus.pending_o), 32'h0008);
        chk("lu_stall1", 32'(bus.stall_o), 32'd1);
        chk("lu_issue1", 32'(bus.issue_o), 32'd0);
        tick;
        #1;
        chk("lu_stall2", 32'(bus.stall_o), 32'd1);
        tick;
        ldret(1'b1, 4'd3);
        #1;
        chk("lu_byp_stall", 32'(bus.stall_o), 32'd0);
        chk("lu_byp_issue", 32'(bus.issue_o), 32'd1);
        tick;
        drive(1'b0, OP_NOP, 4'd0, 4'd0);
        ldret(1'b0, 4'd0);
        #1;
        chk("lu_clr", 32'(bus.pending_o), 32'h0);

        // MUL_L: two stall cycles, done on the second, next op at t+3
        tick;
        drive(1'b1, OP_MUL_L, 4'd1, 4'd2);
        #1;
        chk("mul_issue", 32'(bus.issue_o), 32'd1);
        tick;
        drive(1'b1, OP_ADD_L, 4'd4, 4'd5);
        #1;
        chk("mul_t1_stall", 32'(bus.stall_o), 32'd1);
        chk("mul_t1_mcd", 32'(bus.mc_done_o), 32'd0);
        tick;
        #1;
        chk("mul_t2_stall", 32'(bus.stall_o), 32'd1);
        chk("mul_t2_mcd", 32'(bus.mc_done_o), 32'd1);
        tick;
        #1;
        chk("mul_t3_stall", 32'(bus.stall_o), 32'd0);
        chk("mul_t3_issue", 32'(bus.issue_o), 32'd1);
        chk("mul_t3_mcd", 32'(bus.mc_done_o), 32'd0);

        // UDIV_L: 31 stalls, flush mid-op ignored, single done pulse
        tick;
        drive(1'b1, OP_UDIV_L, 4'd1, 4'd2);
        #1;
        chk("div_issue", 32'(bus.issue_o), 32'd1);
        n_st = 0;
        n_mc = 0;
        mc_at = 0;
        for (int i = 1; i <= 36; i++) begin
            tick;
            drive(1'b0, OP_NOP, 4'd0, 4'd0);
            bus.flush_i = (i == 10);
            #1;
            if (bus.stall_o) n_st++;
            if (bus.mc_done_o) begin
                n_mc++;
                mc_at = i;
            end
        end
        bus.flush_i = 1'b0;
        chk("div_stalls", 32'(n_st), 32'd31);
        chk("div_mc_cnt", 32'(n_mc), 32'd1);
        chk("div_mc_at", 32'(mc_at), 32'd31);

        // same-cycle clear and new load to r5: set wins
        tick;
        drive(1'b1, OP_LDI_L, 4'd5, 4'd0);
        #1;
        chk("r5_issue1", 32'(bus.issue_o), 32'd1);
        tick;
        drive(1'b1, OP_LD_L, 4'd5, 4'd0);
        ldret(1'b1, 4'd5);
        #1;
        chk("r5_pend", 32'(bus.pending_o), 32'h0020);
        chk("r5_issue2", 32'(bus.issue_o), 32'd1);
        tick;
        drive(1'b0, OP_NOP, 4'd0, 4'd0);
        ldret(1'b0, 4'd0);
        #1;
        chk("r5_setwins", 32'(bus.pending_o), 32'h0020);
        ldret(1'b1, 4'd5);
        tick;
        ldret(1'b1, 4'd9);
        #1;
        chk("r5_clr", 32'(bus.pending_o), 32'h0);
        tick;
        ldret(1'b0, 4'd0);
        #1;
        chk("idle_clr", 32'(bus.pending_o), 32'h0);

        // flushed load to r7 never reaches the scoreboard
        drive(1'b1, OP_LDO_S, 4'd7, 4'd0);
        bus.flush_i = 1'b1;
        #1;
        chk("fl_issue", 32'(bus.issue_o), 32'd0);
        tick;
        drive(1'b0, OP_NOP, 4'd0, 4'd0);
        bus.flush_i = 1'b0;
        #1;
        chk("fl_pend", 32'(bus.pending_o), 32'h0);

        // reset in the middle of a DIV with r0/r4 pending
        drive(1'b1, OP_LDI_L, 4'd0, 4'd1);
        tick;
        drive(1'b1, OP_LDB_L_SUB(), 4'd4, 4'd1);
        tick;
        drive(1'b1, OP_DIV_L, 4'd2, 4'd3);
        #1;
        chk("rd_pend", 32'(bus.pending_o), 32'h0011);
        chk("rd_issue", 32'(bus.issue_o), 32'd1);
        n_mc = 0;
        for (int i = 1; i <= 10; i++) begin
            tick;
            drive(1'b1, OP_ADD_L, 4'd6, 4'd8);
            #1;
            if (bus.mc_done_o) n_mc++;
        end
        chk("rd_busy", 32'(bus.stall_o), 32'd1);
        rst = 1'b1;
        #1;
        chk("rd_pend0", 32'(bus.pending_o), 32'h0);
        chk("rd_stall0", 32'(bus.stall_o), 32'd0);
        chk("rd_issue0", 32'(bus.issue_o), 32'd0);
        chk("rd_mcd0", 32'(bus.mc_done_o), 32'd0);
        tick;
        rst = 1'b0;
        drive(1'b0, OP_NOP, 4'd0, 4'd0);
        for (int i = 1; i <= 36; i++) begin
            tick;
            #1;
            if (bus.mc_done_o) n_mc++;
        end
        chk("rd_no_mcd", 32'(n_mc), 32'd0);
        chk("rd_idle", 32'(bus.stall_o), 32'd0);
        drive(1'b1, OP_ADD_L, 4'd0, 4'd4);
        #1;
        chk("rd_post_issue", 32'(bus.issue_o), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    function automatic logic [5:0] OP_LDB_L_SUB();
        return OP_LDA_B;
    endfunction

endmodule

// File: doc/cpu_interlock.md
CPU_INTERLOCK -- requirements
Module: cpu_interlock

Interface
REQ-001 SHALL expose clk_i  input  1  core clock; all state updates on rising edge.
REQ-002 SHALL expose rst_i  input  1  asynchronous, active-high reset.
REQ-003 SHALL expose valid_i  input  1  decoded instruction present at execute boundary.
REQ-004 SHALL expose op_i  input  6  decoded op code (`OP_* encoding).
REQ-005 SHALL expose riA_i / riB_i  input  4 each  source/destination register indices of the presented instruction.
REQ-006 SHALL expose flush_i  input  1  taken branch/jump, which kills the presented instruction.
REQ-007 SHALL expose ld_done_i  input  1 and ld_index_i  input  4  memory stage returning load data for register ld_index_i.
REQ-008 SHALL expose stall_o  output  1  freeze fetch/decode; it drives decode stall_i.
REQ-009 SHALL expose issue_o  output  1  presented instruction accepted into execute this cycle.
REQ-010 SHALL expose mc_done_o  output  1  one-cycle pulse when a multi-cycle op completes.
REQ-011 SHALL expose pending_o  output  16  scoreboard of outstanding load destinations.

Function
REQ-012 SHALL treat LDI_L/B/S, LDA_L/B/S, LD_L/B/S and LDO_L/B/S as loads writing riA_i.
REQ-013 SHALL treat MUL_L as multi-cycle with N=3, and DIV_L, UDIV_L, MOD_L, UMOD_L as multi-cycle with N=32.
REQ-014 SHALL compute hazard = valid_i & (pend_eff[riA_i] | pend_eff[riB_i]), where pend_eff is pending_o with bit ld_index_i cleared when ld_done_i=1 (same-cycle bypass).
REQ-015 SHALL drive stall_o combinationally = hazard | (state==MULTI).
REQ-016 SHALL drive issue_o = valid_i & ~stall_o & ~flush_i; flush_i suppresses issue with zero latency.
REQ-017 SHALL set pending_o[riA_i] on the edge following an issued load.
REQ-018 SHALL clear pending_o[ld_index_i] on the edge following ld_done_i; when set and clear target the same index in one cycle, set SHALL win.
REQ-019 SHALL ignore ld_done_i for an index whose bit is already 0 (no error, no state change).
REQ-020 SHALL implement FSM states IDLE and MULTI; IDLE->MULTI on issue of a multi-cycle op, loading count with N-2.
REQ-021 SHALL, in MULTI, decrement count each cycle, and SHALL transition MULTI->IDLE when count==0, with mc_done_o=1 on that cycle.
REQ-022 SHALL therefore hold stall_o high for exactly N-1 cycles after the issue cycle (MUL: 2, DIV family: 31).
REQ-023 SHALL NOT let flush_i abort MULTI, because the running op is older than the branch.
REQ-024 SHALL keep the scoreboard updating from ld_done_i while in MULTI.
REQ-025 SHALL use a 5-bit unsigned counter that never wraps below 0.

Reset
REQ-026 SHALL, on rst_i assertion (asynchronous), force state=IDLE, count=0 and pending_o=16'h0000; mc_done_o SHALL be 0.
REQ-027 SHALL abandon a multi-cycle op when reset asserts mid-operation, with no mc_done_o pulse.
REQ-028 SHALL hold stall_o=0 and issue_o=0 during reset regardless of valid_i.

Structure
REQ-029 SHALL take op encodings from the shared `OP_* defines, and SHALL add MUL_LAT=3 and DIV_LAT=32 there.
REQ-030 SHALL place the 16-entry scoreboard in sub-module cpu_scoreboard (set/clear/bypass read ports); the FSM and counter SHALL remain top-level.

Verification
REQ-031 SHALL cover: issue LDA_L riA=3, next cycle ADD_L riB=3, no ld_done -> stall_o=1 until ld_done_i with ld_index_i=3, then issue_o=1 in that same cycle.
REQ-032 SHALL cover: MUL_L issued at cycle t -> stall_o=1 at t+1..t+2, mc_done_o=1 at t+2, and a following instruction issues at t+3.
REQ-033 SHALL cover: UDIV_L issued -> exactly 31 stall cycles, with flush_i pulsed mid-op ignored and mc_done_o pulsed once.
REQ-034 SHALL cover: same cycle ld_done_i index 5 and a new load issued to riA=5 -> pending_o[5]=1 afterwards.
REQ-035 SHALL cover: valid_i=1 with flush_i=1 on a load to r7 -> issue_o=0 and pending_o[7] stays 0.
REQ-036 SHALL cover: rst_i asserted at DIV cycle 10 with pending_o=16'h0011 -> state IDLE, pending_o=0, stall_o=0, no mc_done_o pulse.
